// File: rtl/smoldvi_deserialiser_pkg.sv
// rtl/smoldvi_deserialiser_pkg.sv - TMDS control symbols, FSM encoding and phase helper
package smoldvi_deserialiser_pkg;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam logic [2:0] PHASE_LAST = 3'd4;

  // Modulo-5 add; step is at most 2 so one conditional subtract suffices.
  function automatic logic [2:0] phase_step(input logic [2:0] p, input logic [2:0] step);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, step};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

endpackage

// File: rtl/smoldvi_deserialiser.sv
// rtl/smoldvi_deserialiser.sv - 2-bit DDR to 10-bit TMDS symbol deserialiser with bit-slip alignment
module smoldvi_deserialiser
  import smoldvi_deserialiser_pkg::*;
#(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WORDS  = 64,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       clk_x5,
  input  logic       rst_n_x5,
  input  logic [1:0] d,
  output logic [9:0] q,
  output logic       q_valid,
  output logic       q_is_ctrl,
  output logic [1:0] q_ctrl,
  output logic       locked,
  output logic [3:0] align
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WORD_W = $clog2(SEARCH_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_WORDS + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
  localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(SEARCH_WORDS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_WORDS);

  // Only sr[11:3] can reach a word; the lower stream bits are never read.
  logic [11:3]       r_sr;
  logic [2:0]        r_phase;
  logic              r_odd;
  logic [3:0]        r_align;
  logic              r_state;
  logic              r_skip;
  logic [WORD_W-1:0] r_words;
  logic [RUN_W-1:0]  r_run;
  logic [IDLE_W-1:0] r_idle;
  logic [9:0]        r_q;
  logic              r_q_valid;
  logic              r_q_is_ctrl;
  logic [1:0]        r_q_ctrl;

  logic [11:1]       w_sr_next;
  logic [9:0]        w_word;
  logic              w_strobe;
  logic              w_count;
  logic              w_is_ctrl;
  logic [1:0]        w_ctrl;
  logic [WORD_W-1:0] w_words_inc;
  logic [RUN_W-1:0]  w_run_inc;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              w_lock_hit;
  logic              w_slip;
  logic              w_timeout;

  assign w_sr_next = {d, r_sr[11:3]};
  assign w_strobe  = (r_phase == PHASE_LAST);
  assign w_word    = r_odd ? w_sr_next[10:1] : w_sr_next[11:2];
  assign w_count   = w_strobe && !r_skip;

  always_comb begin
    w_is_ctrl = 1'b0;
    w_ctrl    = 2'b00;
    case (w_word)
      CTRL_00: begin w_is_ctrl = 1'b1; w_ctrl = 2'b00; end
      CTRL_01: begin w_is_ctrl = 1'b1; w_ctrl = 2'b01; end
      CTRL_10: begin w_is_ctrl = 1'b1; w_ctrl = 2'b10; end
      CTRL_11: begin w_is_ctrl = 1'b1; w_ctrl = 2'b11; end
      default: begin w_is_ctrl = 1'b0; w_ctrl = 2'b00; end
    endcase
  end

  assign w_words_inc = (r_words == WORD_MAX) ? r_words : r_words + WORD_W'(1);
  assign w_run_inc   = !w_is_ctrl ? '0 : ((r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1));
  assign w_idle_inc  = w_is_ctrl ? '0 : ((r_idle == IDLE_MAX) ? r_idle : r_idle + IDLE_W'(1));

  // A lock on the word that also closes the search window takes priority over the slip.
  assign w_lock_hit = (r_state == ST_HUNT) && w_count && (w_run_inc == RUN_MAX);
  assign w_slip     = (r_state == ST_HUNT) && w_count && !w_lock_hit && (w_words_inc == WORD_MAX);
  assign w_timeout  = (r_state == ST_LOCKED) && w_count && (w_idle_inc == IDLE_MAX);

  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      r_sr        <= '0;
      r_phase     <= '0;
      r_odd       <= 1'b0;
      r_align     <= '0;
      r_state     <= ST_HUNT;
      r_skip      <= 1'b0;
      r_words     <= '0;
      r_run       <= '0;
      r_idle      <= '0;
      r_q         <= '0;
      r_q_valid   <= 1'b0;
      r_q_is_ctrl <= 1'b0;
      r_q_ctrl    <= '0;
    end else begin
      r_sr      <= w_sr_next[11:3];
      // Leaving odd alignment pulls the next strobe one cycle earlier.
      r_phase   <= phase_step(r_phase, (w_slip && r_odd) ? 3'd2 : 3'd1);
      r_q_valid <= w_strobe;

      if (w_strobe) begin
        r_q         <= w_word;
        r_q_is_ctrl <= w_is_ctrl;
        r_q_ctrl    <= w_ctrl;
        r_skip      <= w_slip;
      end

      if (w_slip) begin
        r_odd   <= ~r_odd;
        r_align <= (r_align == 4'd9) ? 4'd0 : r_align + 4'd1;
      end

      if (w_count) begin
        if (r_state == ST_HUNT) begin
          if (w_lock_hit) begin
            r_state <= ST_LOCKED;
            r_words <= '0;
            r_run   <= '0;
          end else if (w_slip) begin
            r_words <= '0;
            r_run   <= '0;
          end else begin
            r_words <= w_words_inc;
            r_run   <= w_run_inc;
          end
        end else begin
          if (w_timeout) begin
            r_state <= ST_HUNT;
            r_idle  <= '0;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
      end
    end
  end

  assign q         = r_q;
  assign q_valid   = r_q_valid;
  assign q_is_ctrl = r_q_is_ctrl;
  assign q_ctrl    = r_q_ctrl;
  assign locked    = r_state;
  assign align     = r_align;

endmodule

// File: tb/tb_smoldvi_deserialiser.sv
// tb/tb_smoldvi_deserialiser.sv - randomized bit-stream bench for smoldvi_deserialiser
module tb_smoldvi_deserialiser;

  logic       clk_x5 = 1'b0;
  logic       rst_n_x5 = 1'b0;
  logic [1:0] d = 2'b00;
  logic [9:0] q;
  logic       q_valid;
  logic       q_is_ctrl;
  logic [1:0] q_ctrl;
  logic       locked;
  logic [3:0] align;

  int n_checks = 0;
  int n_fail = 0;
  bit bits[$];

  smoldvi_deserialiser dut (
    .clk_x5    (clk_x5),
    .rst_n_x5  (rst_n_x5),
    .d         (d),
    .q         (q),
    .q_valid   (q_valid),
    .q_is_ctrl (q_is_ctrl),
    .q_ctrl    (q_ctrl),
    .locked    (locked),
    .align     (align)
  );

  always #5 clk_x5 = ~clk_x5;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ctrl_code(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bits.push_back(s[i]);
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    do s = 10'($urandom_range(0, 1023)); while (ctrl_code(s) >= 0);
    return s;
  endfunction

  // Reference: words are windows of the bit stream ending at bit e; a slip shortens the next window gap to 9.
  task automatic run_stream();
    int e, m_align, m_words, m_run, m_idle, cyc, code;
    bit m_locked, m_skip, slip, exp_valid;
    logic [9:0] exp_q;
    rst_n_x5 = 1'b0;
    d = 2'b00;
    repeat (3) @(negedge clk_x5);
    e = 9; m_align = 0; m_words = 0; m_run = 0; m_idle = 0;
    m_locked = 0; m_skip = 0;
    cyc = 0;
    while (2 * cyc + 1 < bits.size()) begin
      if (cyc == 0) begin
        rst_n_x5 = 1'b1;
        check_eq("reset_q_valid", q_valid, 0);
        check_eq("reset_q", q, 0);
        check_eq("reset_locked", locked, 0);
        check_eq("reset_align", align, 0);
      end else begin
        exp_valid = (e / 2 == cyc - 1);
        check_eq("q_valid", q_valid, exp_valid);
        if (exp_valid) begin
          for (int i = 0; i < 10; i++) exp_q[i] = bits[e - 9 + i];
          code = ctrl_code(exp_q);
          check_eq("q", q, exp_q);
          check_eq("q_is_ctrl", q_is_ctrl, code >= 0);
          check_eq("q_ctrl", q_ctrl, (code >= 0) ? code : 0);
          slip = 0;
          if (!m_skip) begin
            if (!m_locked) begin
              m_words++;
              m_run = (code >= 0) ? m_run + 1 : 0;
              if (m_run == 16) begin
                m_locked = 1; m_words = 0; m_run = 0;
              end else if (m_words == 64) begin
                slip = 1; m_words = 0; m_run = 0;
                m_align = (m_align + 1) % 10;
              end
            end else begin
              m_idle = (code >= 0) ? 0 : m_idle + 1;
              if (m_idle == 4096) begin
                m_locked = 0; m_idle = 0;
              end
            end
          end
          m_skip = slip;
          e += slip ? 9 : 10;
          check_eq("locked", locked, m_locked);
          check_eq("align", align, m_align);
        end
      end
      d = {bits[2 * cyc + 1], bits[2 * cyc]};
      @(negedge clk_x5);
      cyc++;
    end
  endtask

  initial begin
    // Aligned blanking stream locks at align 0.
    bits.delete();
    repeat (40) push_sym(10'h354);
    run_stream();
    check_eq("t1_locked", locked, 1);
    check_eq("t1_align", align, 0);
    check_eq("t1_q", q, 10'h354);
    check_eq("t1_q_ctrl", q_ctrl, 0);

    // Three-bit offset needs seven slips.
    bits.delete();
    repeat (3) bits.push_back(1'($urandom_range(0, 1)));
    repeat (7 * 65 + 40) push_sym(10'h354);
    run_stream();
    check_eq("t2_locked", locked, 1);
    check_eq("t2_align", align, 7);
    check_eq("t2_q", q, 10'h354);

    // Pure data: keeps slipping, wraps align, never locks.
    bits.delete();
    repeat (700) push_sym(rand_data());
    run_stream();
    check_eq("t3_locked", locked, 0);

    // Lock, idle run reset by one 2AB, then timeout.
    bits.delete();
    repeat (20) push_sym(10'h354);
    repeat (4000) push_sym(rand_data());
    push_sym(10'h2AB);
    repeat (4100) push_sym(rand_data());
    run_stream();
    check_eq("t4_locked", locked, 0);

    // Fifteen control words then a data word never reaches the lock count.
    bits.delete();
    repeat (30) begin
      repeat (15) push_sym(10'h354);
      push_sym(rand_data());
    end
    run_stream();
    check_eq("t5_locked", locked, 0);

    // Lock at align 5, then asynchronous reset mid-word.
    bits.delete();
    repeat (5) bits.push_back(1'($urandom_range(0, 1)));
    repeat (5 * 65 + 30) push_sym(10'h354);
    run_stream();
    check_eq("t6_locked", locked, 1);
    check_eq("t6_align", align, 5);
    @(posedge clk_x5);
    #2 rst_n_x5 = 1'b0;
    #1;
    check_eq("t6_rst_q", q, 0);
    check_eq("t6_rst_q_valid", q_valid, 0);
    check_eq("t6_rst_q_is_ctrl", q_is_ctrl, 0);
    check_eq("t6_rst_q_ctrl", q_ctrl, 0);
    check_eq("t6_rst_locked", locked, 0);
    check_eq("t6_rst_align", align, 0);
    bits.delete();
    repeat (30) push_sym(10'h354);
    run_stream();
    check_eq("t6_relock", locked, 1);
    check_eq("t6_relock_align", align, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
